// File: rtl/complex_butterfly_pipe_cfg.sv
// Radix-2 DIT complex butterfly, 3-stage valid/ready pipeline: dout1 = din3 + W*din1, dout2 = din3 - W*din1.
// Optional sticky growth detector enabled by defining BUTTERFLY_GROWTH_DET_EN.
module complex_butterfly_pipe_cfg #(
   parameter int IWL1 = 16,
   parameter int IWL2 = 16,
   parameter int OWL  = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic signed [IWL1-1:0] din1_re,
   input  logic signed [IWL1-1:0] din1_im,
   input  logic signed [IWL2-1:0] din2_re,
   input  logic signed [IWL2-1:0] din2_im,
   input  logic signed [IWL1-1:0] din3_re,
   input  logic signed [IWL1-1:0] din3_im,
   input  logic [1:0]             scale_sel,
   input  logic                   inverse,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic signed [OWL-1:0]  dout1_re,
   output logic signed [OWL-1:0]  dout1_im,
   output logic signed [OWL-1:0]  dout2_re,
   output logic signed [OWL-1:0]  dout2_im,
   output logic                   ovf,
   input  logic                   ovf_clr
`ifdef BUTTERFLY_GROWTH_DET_EN
   ,
   output logic                   grow_det
`endif
);

   localparam int PROD_WL = IWL1 + IWL2;
   localparam int SUM_WL  = PROD_WL + 2;
   localparam int EXT_WL  = SUM_WL + 2;
   // Shift from the product's fractional point down to the output LSB at scale 0.
   localparam int FRAC_SH = PROD_WL - 1 - OWL;

   // Returns {saturated, value}: divide by 2^scale, round half up to the output LSB, clamp.
   function automatic logic [OWL:0] round_sat(input logic signed [SUM_WL-1:0] v, input logic [1:0] sc);
      logic signed [EXT_WL-1:0] e;
      logic signed [EXT_WL-1:0] half;
      logic signed [EXT_WL-1:0] r;
      int                       sh;
      sh = FRAC_SH + ((sc == 2'd0) ? 0 : ((sc == 2'd1) ? 1 : 2));
      e = EXT_WL'(v) <<< 1;
      half = '0;
      half[sh] = 1'b1;
      r = (e + half) >>> (sh + 1);
      if (r[EXT_WL-1] && !(&r[EXT_WL-1:OWL-1])) begin
         round_sat = {1'b1, 1'b1, {(OWL-1){1'b0}}};
      end else if (!r[EXT_WL-1] && (|r[EXT_WL-1:OWL-1])) begin
         round_sat = {1'b1, 1'b0, {(OWL-1){1'b1}}};
      end else begin
         round_sat = {1'b0, r[OWL-1:0]};
      end
   endfunction

   logic                     adv_s;
   logic                     s1_valid_r, s2_valid_r;
   logic signed [IWL1-1:0]   a_re_r, a_im_r, b_re_r, b_im_r;
   logic signed [IWL2-1:0]   w_re_r, w_im_r, wim_s;
   logic [1:0]               s1_scale_r, s2_scale_r;
   logic                     s1_inv_r;
   logic signed [PROD_WL-1:0] p_rr_r, p_ii_r, p_ri_r, p_ir_r;
   logic signed [IWL1-1:0]   s2_b_re_r, s2_b_im_r;
   logic signed [SUM_WL-1:0] pr_s, pi_s, bre_al_s, bim_al_s;
   logic [OWL:0]             r1re_s, r1im_s, r2re_s, r2im_s;
   logic                     sat_any_s, grow_any_s;

   assign adv_s    = !out_valid || out_ready;
   assign in_ready = adv_s;

   // Conjugate twiddle for inverse beats; the most negative code negates to the most positive.
   always_comb begin
      wim_s = w_im_r;
      if (s1_inv_r) begin
         if (w_im_r == {1'b1, {(IWL2-1){1'b0}}}) begin
            wim_s = {1'b0, {(IWL2-1){1'b1}}};
         end else begin
            wim_s = -w_im_r;
         end
      end else begin
         wim_s = w_im_r;
      end
   end

   // Final stage arithmetic: complex product sums, din3 aligned to the product's fractional point.
   always_comb begin
      pr_s       = SUM_WL'(p_rr_r) - SUM_WL'(p_ii_r);
      pi_s       = SUM_WL'(p_ri_r) + SUM_WL'(p_ir_r);
      bre_al_s   = SUM_WL'(s2_b_re_r) <<< (IWL2 - 1);
      bim_al_s   = SUM_WL'(s2_b_im_r) <<< (IWL2 - 1);
      r1re_s     = round_sat(bre_al_s + pr_s, s2_scale_r);
      r1im_s     = round_sat(bim_al_s + pi_s, s2_scale_r);
      r2re_s     = round_sat(bre_al_s - pr_s, s2_scale_r);
      r2im_s     = round_sat(bim_al_s - pi_s, s2_scale_r);
      sat_any_s  = r1re_s[OWL] | r1im_s[OWL] | r2re_s[OWL] | r2im_s[OWL];
      grow_any_s = (r1re_s[OWL-1] ^ r1re_s[OWL-2]) | (r1im_s[OWL-1] ^ r1im_s[OWL-2]) |
                   (r2re_s[OWL-1] ^ r2re_s[OWL-2]) | (r2im_s[OWL-1] ^ r2im_s[OWL-2]);
   end

   // Datapath stages S1 and S2; they only move when the whole pipe advances.
   always_ff @(posedge clk) begin
      if (adv_s) begin
         a_re_r     <= din1_re;
         a_im_r     <= din1_im;
         w_re_r     <= din2_re;
         w_im_r     <= din2_im;
         b_re_r     <= din3_re;
         b_im_r     <= din3_im;
         s1_scale_r <= scale_sel;
         s1_inv_r   <= inverse;
         p_rr_r     <= PROD_WL'(w_re_r) * PROD_WL'(a_re_r);
         p_ii_r     <= PROD_WL'(wim_s) * PROD_WL'(a_im_r);
         p_ri_r     <= PROD_WL'(w_re_r) * PROD_WL'(a_im_r);
         p_ir_r     <= PROD_WL'(wim_s) * PROD_WL'(a_re_r);
         s2_b_re_r  <= b_re_r;
         s2_b_im_r  <= b_im_r;
         s2_scale_r <= s2_scale_r;
         s2_scale_r <= s1_scale_r;
      end
   end

   // Stage valids, output register and sticky flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_r <= 1'b0;
         s2_valid_r <= 1'b0;
         out_valid  <= 1'b0;
         dout1_re   <= '0;
         dout1_im   <= '0;
         dout2_re   <= '0;
         dout2_im   <= '0;
         ovf        <= 1'b0;
      end else begin
         if (adv_s) begin
            s1_valid_r <= in_valid;
            s2_valid_r <= s1_valid_r;
            out_valid  <= s2_valid_r;
            if (s2_valid_r) begin
               dout1_re <= r1re_s[OWL-1:0];
               dout1_im <= r1im_s[OWL-1:0];
               dout2_re <= r2re_s[OWL-1:0];
               dout2_im <= r2im_s[OWL-1:0];
            end
         end
         if (adv_s && s2_valid_r && sat_any_s) begin
            ovf <= 1'b1;
         end else if (ovf_clr) begin
            ovf <= 1'b0;
         end
      end
   end

`ifdef BUTTERFLY_GROWTH_DET_EN
   // Sticky growth flag, same set-over-clear priority as ovf.
   always_ff @(posedge clk) begin
      if (rst) begin
         grow_det <= 1'b0;
      end else if (adv_s && s2_valid_r && grow_any_s) begin
         grow_det <= 1'b1;
      end else if (ovf_clr) begin
         grow_det <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_complex_butterfly_pipe_cfg.sv
// Randomized and directed bench for complex_butterfly_pipe_cfg against an arithmetic reference model.
module tb_complex_butterfly_pipe_cfg;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst, in_valid, in_ready, out_valid, out_ready, inverse, ovf, ovf_clr;
   logic signed [15:0] din1_re, din1_im, din2_re, din2_im, din3_re, din3_im;
   logic [1:0]         scale_sel;
   logic [15:0]        dout1_re, dout1_im, dout2_re, dout2_im;
`ifdef BUTTERFLY_GROWTH_DET_EN
   logic               grow_det;
   bit                 grow_m = 1'b0;
`endif

   complex_butterfly_pipe_cfg #(.IWL1(16), .IWL2(16), .OWL(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .din1_re(din1_re), .din1_im(din1_im), .din2_re(din2_re), .din2_im(din2_im),
      .din3_re(din3_re), .din3_im(din3_im), .scale_sel(scale_sel), .inverse(inverse),
      .out_valid(out_valid), .out_ready(out_ready),
      .dout1_re(dout1_re), .dout1_im(dout1_im), .dout2_re(dout2_re), .dout2_im(dout2_im),
      .ovf(ovf), .ovf_clr(ovf_clr)
`ifdef BUTTERFLY_GROWTH_DET_EN
      , .grow_det(grow_det)
`endif
   );

   typedef struct {
      logic [15:0] d[4];
      bit          sat;
   } beat_t;

   int    n_cmp = 0;
   int    n_bad = 0;
   beat_t q[$];

   task automatic chk(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Exact value of din3 +/- W'*din1 in units of 2^-30, scaled, rounded half up, clamped.
   function automatic beat_t model(input logic signed [15:0] a_re, a_im, w_re, w_im, b_re, b_im,
                                   input logic [1:0] sc, input logic inv);
      beat_t  m;
      longint ar, ai, wr, wi, br, bi, pr, pi, dv, r;
      longint y[4];
      int     sh;
      ar = a_re; ai = a_im; wr = w_re; br = b_re; bi = b_im;
      wi = w_im;
      if (inv) wi = -wi;
      if (wi > 32767) wi = 32767;
      pr = wr * ar - wi * ai;
      pi = wr * ai + wi * ar;
      y[0] = br * 32768 + pr;
      y[1] = bi * 32768 + pi;
      y[2] = br * 32768 - pr;
      y[3] = bi * 32768 - pi;
      sh = (sc == 2'd3) ? 2 : int'(sc);
      dv = 1;
      dv = dv << (15 + sh);
      m.sat = 1'b0;
      for (int k = 0; k < 4; k++) begin
         r = (2 * y[k] + dv) >>> (16 + sh);
         if (r > 32767) begin r = 32767; m.sat = 1'b1; end
         if (r < -32768) begin r = -32768; m.sat = 1'b1; end
         m.d[k] = 16'(r);
      end
      return m;
   endfunction

   // Monitor: sampled on the falling edge, where all inputs and outputs are settled.
   bit          prev_rst = 1'b0, prev_stall = 1'b0, prev_clr = 1'b0, ovf_m = 1'b0;
   logic [15:0] prev_d[4];
   always @(negedge clk) begin
      beat_t e;
      bit    new_beat, gr;
      if (rst) begin
         q.delete();
         ovf_m = 1'b0;
`ifdef BUTTERFLY_GROWTH_DET_EN
         grow_m = 1'b0;
`endif
         prev_rst = 1'b1;
         prev_stall = 1'b0;
         prev_clr = 1'b0;
      end else begin
         if (prev_rst) begin
            chk("post_rst_out_valid", out_valid, 0);
            chk("post_rst_dout", {dout1_re, dout1_im, dout2_re, dout2_im}, 0);
            chk("post_rst_ovf", ovf, 0);
         end else begin
            new_beat = out_valid && !prev_stall;
            gr = 1'b0;
            if (prev_stall) begin
               chk("stall_out_valid", out_valid, 1);
               chk("stall_hold", {dout1_re, dout1_im, dout2_re, dout2_im},
                   {prev_d[0], prev_d[1], prev_d[2], prev_d[3]});
            end
            if (new_beat) begin
               if (q.size() == 0) begin
                  chk("unexpected_output", 1, 0);
               end else begin
                  e = q[0];
                  chk("dout1_re", dout1_re, e.d[0]);
                  chk("dout1_im", dout1_im, e.d[1]);
                  chk("dout2_re", dout2_re, e.d[2]);
                  chk("dout2_im", dout2_im, e.d[3]);
                  for (int k = 0; k < 4; k++) gr |= (e.d[k][15] != e.d[k][14]);
               end
            end
            if (new_beat && q.size() > 0 && q[0].sat) ovf_m = 1'b1;
            else if (prev_clr) ovf_m = 1'b0;
            chk("ovf", ovf, ovf_m);
`ifdef BUTTERFLY_GROWTH_DET_EN
            if (gr) grow_m = 1'b1;
            else if (prev_clr) grow_m = 1'b0;
            chk("grow_det", grow_det, grow_m);
`endif
         end
         chk("in_ready", in_ready, (!out_valid || out_ready));
         if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
         if (in_valid && in_ready)
            q.push_back(model(din1_re, din1_im, din2_re, din2_im, din3_re, din3_im, scale_sel, inverse));
         prev_stall = out_valid && !out_ready;
         prev_d[0] = dout1_re; prev_d[1] = dout1_im; prev_d[2] = dout2_re; prev_d[3] = dout2_im;
         prev_clr = ovf_clr;
         prev_rst = 1'b0;
      end
   end

   task automatic drive(input logic [15:0] a_re, a_im, w_re, w_im, b_re, b_im,
                        input logic [1:0] sc, input logic inv);
      din1_re = a_re; din1_im = a_im; din2_re = w_re; din2_im = w_im;
      din3_re = b_re; din3_im = b_im; scale_sel = sc; inverse = inv;
   endtask

   // Sends one beat into an idle pipe and captures the first result and its latency.
   task automatic one_beat(input logic [15:0] a_re, a_im, w_re, w_im, b_re, b_im,
                           input logic [1:0] sc, input logic inv,
                           output logic [15:0] o1r, o1i, o2r, o2i, output logic ov, output int lat);
      @(posedge clk); #1;
      drive(a_re, a_im, w_re, w_im, b_re, b_im, sc, inv);
      in_valid = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = -1;
      o1r = 16'h0; o1i = 16'h0; o2r = 16'h0; o2i = 16'h0; ov = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (out_valid && lat < 0) begin
            lat = k;
            o1r = dout1_re; o1i = dout1_im; o2r = dout2_re; o2i = dout2_im; ov = ovf;
         end
      end
   endtask

   function automatic logic [15:0] pick16();
      case ($urandom_range(0, 7))
         0: pick16 = 16'h8000;
         1: pick16 = 16'h7FFF;
         default: pick16 = 16'($urandom);
      endcase
   endfunction

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] o1r, o1i, o2r, o2i;
      logic        ov;
      int          lat, sent, seen, acc;
      beat_t       m;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
      drive(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 2'd0, 1'b0);

      m = model(16'h4000, 16'h0, 16'h7FFF, 16'h0, 16'h2000, 16'h0, 2'd0, 1'b0);
      chk("model_round_d1", m.d[0], 16'h6000);
      chk("model_round_d2", m.d[2], 16'hE001);
      m = model(16'h7FFF, 16'h0, 16'h7FFF, 16'h0, 16'h7FFF, 16'h0, 2'd1, 1'b0);
      chk("model_sat_s1_d2", m.d[2], 16'h0000);
      m = model(16'h4000, 16'h0, 16'h0, 16'h7FFF, 16'h0, 16'h0, 2'd0, 1'b1);
      chk("model_inv_d1im", m.d[1], 16'hC001);

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      one_beat(16'h4000, 16'h0, 16'h7FFF, 16'h0, 16'h2000, 16'h0, 2'd0, 1'b0, o1r, o1i, o2r, o2i, ov, lat);
      chk("t1_latency", lat, 3);
      chk("t1_dout1_re", o1r, 16'h6000);
      chk("t1_dout2_re", o2r, 16'hE001);
      chk("t1_im", {o1i, o2i}, 0);
      chk("t1_ovf", ov, 0);

      one_beat(16'h4000, 16'h0, 16'h0, 16'h7FFF, 16'h0, 16'h0, 2'd0, 1'b0, o1r, o1i, o2r, o2i, ov, lat);
      chk("t3_fwd_d1im", o1i, 16'h4000);
      chk("t3_fwd_d2im", o2i, 16'hC001);
      one_beat(16'h4000, 16'h0, 16'h0, 16'h7FFF, 16'h0, 16'h0, 2'd0, 1'b1, o1r, o1i, o2r, o2i, ov, lat);
      chk("t3_inv_d1im", o1i, 16'hC001);
      chk("t3_inv_d2im", o2i, 16'h4000);

      one_beat(16'h7FFF, 16'h0, 16'h7FFF, 16'h0, 16'h7FFF, 16'h0, 2'd0, 1'b0, o1r, o1i, o2r, o2i, ov, lat);
      chk("t2_sat_d1re", o1r, 16'h7FFF);
      chk("t2_sat_d2re", o2r, 16'h0001);
      chk("t2_sat_ovf", ov, 1);
      @(posedge clk); #1; ovf_clr = 1'b1;
      @(posedge clk); #1; ovf_clr = 1'b0;
      @(negedge clk);
      chk("t2_ovf_cleared", ovf, 0);
      one_beat(16'h7FFF, 16'h0, 16'h7FFF, 16'h0, 16'h7FFF, 16'h0, 2'd1, 1'b0, o1r, o1i, o2r, o2i, ov, lat);
      chk("t2_s1_d1re", o1r, 16'h7FFF);
      chk("t2_s1_d2re", o2r, 16'h0000);
      chk("t2_s1_ovf", ov, 0);

      // Backpressure: eight beats, out_ready low for four cycles starting at cycle 5.
      sent = 0; seen = 0;
      for (int c = 0; c < 40 && seen < 8; c++) begin
         @(posedge clk); #1;
         out_ready = !(c >= 5 && c < 9);
         in_valid = (sent < 8);
         drive(16'h0, 16'h0, 16'h7FFF, 16'h0, 16'(sent + 1), 16'h0, 2'd0, 1'b0);
         @(negedge clk);
         if (c >= 5 && c < 9) chk("bp_in_ready_stall", in_ready, 0);
         if (in_valid && in_ready) sent++;
         if (out_valid && out_ready) begin
            seen++;
            chk("bp_order", dout1_re, seen);
         end
      end
      chk("bp_count", seen, 8);
      @(posedge clk); #1; in_valid = 1'b0; out_ready = 1'b1;

      // Fill the pipe with out_ready low, then reset with three beats in flight.
      @(posedge clk); #1;
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (k == 0) drive(16'h7FFF, 16'h0, 16'h7FFF, 16'h0, 16'h7FFF, 16'h0, 2'd0, 1'b0);
         else drive(16'h1234, 16'h0, 16'h4000, 16'h0, 16'(k), 16'h0, 2'd0, 1'b0);
         in_valid = 1'b1;
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("fill3_in_ready", in_ready, 0);
      chk("fill3_ovf", ovf, 1);
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      chk("t5_out_valid", out_valid, 0);
      chk("t5_dout1_re", dout1_re, 0);
      chk("t5_ovf", ovf, 0);
      one_beat(16'h0, 16'h0, 16'h0, 16'h0, 16'h0123, 16'h0456, 2'd0, 1'b0, o1r, o1i, o2r, o2i, ov, lat);
      chk("t5_latency", lat, 3);
      chk("t5_d1", {o1r, o1i}, {16'h0123, 16'h0456});

      // Mixed sideband: strict alternation first, then fully random settings.
      acc = 0;
      for (int c = 0; c < 600; c++) begin
         @(posedge clk); #1;
         in_valid = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         ovf_clr = ($urandom_range(0, 15) == 0);
         drive(pick16(), pick16(), pick16(), pick16(), pick16(), pick16(), 2'd0, 1'b0);
         if (c < 250) begin
            scale_sel = acc[0] ? 2'd2 : 2'd0;
            inverse = acc[0];
         end else begin
            scale_sel = 2'($urandom_range(0, 3));
            inverse = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
         if (in_valid && in_ready) acc++;
      end
      @(posedge clk); #1; in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
      repeat (8) @(negedge clk);
      chk("drain_empty", q.size(), 0);
      chk("random_beats_accepted", (acc > 200), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
